// File: rtl/report_pkg.sv
// Shared defaults and the buffered report entry layout for the report collector.
package report_pkg;

   localparam int unsigned NUM_REPORTS_DEF    = 8;
   localparam int unsigned OFFSET_W_DEF       = 16;
   localparam int unsigned DEPTH_DEF          = 16;
   localparam int unsigned DROP_W_DEF         = 8;
   localparam int unsigned ALMOST_FULL_MARGIN = 2;

   // Entry as seen by the host-side report path: offset in the upper bits.
   typedef struct packed {
      logic [OFFSET_W_DEF-1:0]    offset;
      logic [NUM_REPORTS_DEF-1:0] vector;
   } report_entry_t;

endpackage

// File: rtl/report_fifo.sv
// Synchronous fall-through FIFO; pointers carry an extra wrap bit so that
// count = wptr - rptr distinguishes full from empty.
module report_fifo #(
   parameter int unsigned WIDTH = 24,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr_q, rptr_q;
   logic             do_push, do_pop;

   assign count   = wptr_q - rptr_q;
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   // Head reads as zero while empty so downstream never sees stale data.
   assign dout    = empty ? '0 : mem[rptr_q[AW-1:0]];

   // Pointer registers; reset discards all stored entries.
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
      end
   end

   // Storage write; contents need no reset since the pointers gate visibility.
   always_ff @(posedge clk) begin
      if (do_push) mem[wptr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/report_collector.sv
// Tags reporting-STE activity with the symbol offset, buffers it and drains
// it over valid/ready, counting reports lost to a full buffer.
module report_collector
   import report_pkg::*;
#(
   parameter int unsigned NUM_REPORTS = NUM_REPORTS_DEF,
   parameter int unsigned OFFSET_W    = OFFSET_W_DEF,
   parameter int unsigned DEPTH       = DEPTH_DEF,
   parameter int unsigned DROP_W      = DROP_W_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   run,
   input  logic                   start_of_data,
   input  logic [NUM_REPORTS-1:0] report_vector,
   output logic                   rpt_valid,
   input  logic                   rpt_ready,
   output logic [OFFSET_W-1:0]    rpt_offset,
   output logic [NUM_REPORTS-1:0] rpt_vector,
   output logic                   almost_full,
   output logic                   overflow,
   output logic [DROP_W-1:0]      dropped_count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned EW = OFFSET_W + NUM_REPORTS;

   logic [OFFSET_W-1:0] offs_q, offs_d, cur_offset;
   logic                push_req, drop, fifo_push, fifo_pop;
   logic                fifo_full, fifo_empty;
   logic [AW:0]         fifo_count, count_next;
   logic [EW-1:0]       fifo_dout;
   logic                almost_full_q, almost_full_d;
   logic                overflow_q, overflow_d;
   logic [DROP_W-1:0]   dropped_q, dropped_d;

   // Offset of the current symbol, push qualification and next-state values.
   always_comb begin
      cur_offset    = start_of_data ? '0 : offs_q;
      offs_d        = offs_q;
      if (run) offs_d = cur_offset + OFFSET_W'(1);
      push_req      = run & (|report_vector);
      // Fullness is judged on start-of-cycle occupancy, so a same-cycle pop
      // does not make room for the push.
      drop          = push_req & fifo_full;
      fifo_push     = push_req & ~fifo_full;
      fifo_pop      = rpt_ready & ~fifo_empty;
      count_next    = fifo_count + (AW+1)'(fifo_push) - (AW+1)'(fifo_pop);
      almost_full_d = (count_next >= (AW+1)'(DEPTH - ALMOST_FULL_MARGIN));
      overflow_d    = overflow_q | drop;
      dropped_d     = dropped_q;
      if (drop && (dropped_q != '1)) dropped_d = dropped_q + 1'b1;
   end

   // Collector state registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         offs_q        <= '0;
         almost_full_q <= 1'b0;
         overflow_q    <= 1'b0;
         dropped_q     <= '0;
      end else begin
         offs_q        <= offs_d;
         almost_full_q <= almost_full_d;
         overflow_q    <= overflow_d;
         dropped_q     <= dropped_d;
      end
   end

   report_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   ({cur_offset, report_vector}),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign rpt_valid                = ~fifo_empty;
   assign {rpt_offset, rpt_vector} = fifo_dout;
   assign almost_full              = almost_full_q;
   assign overflow                 = overflow_q;
   assign dropped_count            = dropped_q;

endmodule

// File: tb/tb_report_collector.sv
// Directed bench for report_collector: table-driven basic vectors, fill/drop
// sequences, a scoreboarded backpressure run and a narrow-offset wrap instance.
module tb_report_collector;
   import report_pkg::*;

   logic        clk = 1'b0;
   logic        reset, run, start_of_data, rpt_ready;
   logic [7:0]  report_vector;
   logic        rpt_valid, almost_full, overflow;
   logic [15:0] rpt_offset;
   logic [7:0]  rpt_vector, dropped_count;
   logic        v4, af4, ovf4;
   logic [3:0]  o4;
   logic [7:0]  vec4, dc4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   report_collector dut (
      .clk           (clk),
      .reset         (reset),
      .run           (run),
      .start_of_data (start_of_data),
      .report_vector (report_vector),
      .rpt_valid     (rpt_valid),
      .rpt_ready     (rpt_ready),
      .rpt_offset    (rpt_offset),
      .rpt_vector    (rpt_vector),
      .almost_full   (almost_full),
      .overflow      (overflow),
      .dropped_count (dropped_count)
   );

   report_collector #(
      .NUM_REPORTS (8),
      .OFFSET_W    (4),
      .DEPTH       (16),
      .DROP_W      (8)
   ) dut4 (
      .clk           (clk),
      .reset         (reset),
      .run           (run),
      .start_of_data (start_of_data),
      .report_vector (report_vector),
      .rpt_valid     (v4),
      .rpt_ready     (rpt_ready),
      .rpt_offset    (o4),
      .rpt_vector    (vec4),
      .almost_full   (af4),
      .overflow      (ovf4),
      .dropped_count (dc4)
   );

   typedef struct {
      logic        run;
      logic        sod;
      logic [7:0]  rv;
      logic        ready;
      logic        valid;
      logic [15:0] off;
      logic [7:0]  vec;
      logic        ovf;
      logic [7:0]  drop;
   } row_t;

   row_t rows[13];

   // Scoreboard state for the backpressure phase
   report_entry_t model_q[$];
   logic [15:0]   model_offs;
   int            model_drop;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic r, input logic s, input logic [7:0] v, input logic rd);
      run = r; start_of_data = s; report_vector = v; rpt_ready = rd;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      tick();
      reset = 1'b0;
   endtask

   // One scoreboarded cycle: compare head to model, apply inputs, advance model.
   task automatic sb_step(input logic r, input logic s, input logic [7:0] v, input logic rd);
      logic          stalled;
      report_entry_t held, ent;
      logic [15:0]   cur;
      bit            full_pre;
      check("sb_valid", rpt_valid, model_q.size() != 0);
      if (model_q.size() != 0) begin
         check("sb_offset", rpt_offset, model_q[0].offset);
         check("sb_vector", rpt_vector, model_q[0].vector);
      end
      stalled = rpt_valid && !rd;
      held    = '{offset: rpt_offset, vector: rpt_vector};
      drive(r, s, v, rd);
      tick();
      cur      = s ? 16'd0 : model_offs;
      full_pre = (model_q.size() == 16);
      if (model_q.size() != 0 && rd) void'(model_q.pop_front());
      if (r && v != 8'h00) begin
         if (full_pre) model_drop++;
         else begin
            ent = '{offset: cur, vector: v};
            model_q.push_back(ent);
         end
      end
      if (r) model_offs = cur + 16'd1;
      if (stalled) begin
         check("stall_offset", rpt_offset, held.offset);
         check("stall_vector", rpt_vector, held.vector);
      end
   endtask

   initial begin
      // Basic vectors: expected outputs are those seen just after the edge.
      rows[0]  = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 16'd0, 8'h00, 1'b0, 8'd0};
      rows[1]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0, 8'h00, 1'b0, 8'd0};
      rows[2]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0, 8'h00, 1'b0, 8'd0};
      rows[3]  = '{1'b1, 1'b0, 8'h05, 1'b0, 1'b1, 16'd3, 8'h05, 1'b0, 8'd0};
      rows[4]  = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 16'd3, 8'h05, 1'b0, 8'd0};
      rows[5]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'd0, 8'h00, 1'b0, 8'd0};
      rows[6]  = '{1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 16'd0, 8'h00, 1'b0, 8'd0};
      rows[7]  = '{1'b0, 1'b0, 8'h80, 1'b0, 1'b0, 16'd0, 8'h00, 1'b0, 8'd0};
      rows[8]  = '{1'b1, 1'b0, 8'h80, 1'b0, 1'b1, 16'd1, 8'h80, 1'b0, 8'd0};
      rows[9]  = '{1'b0, 1'b0, 8'hff, 1'b1, 1'b0, 16'd0, 8'h00, 1'b0, 8'd0};
      rows[10] = '{1'b0, 1'b1, 8'h7f, 1'b0, 1'b0, 16'd0, 8'h00, 1'b0, 8'd0};
      rows[11] = '{1'b1, 1'b0, 8'h01, 1'b0, 1'b1, 16'd2, 8'h01, 1'b0, 8'd0};
      rows[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'd0, 8'h00, 1'b0, 8'd0};

      reset = 1'b1;
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      tick();
      tick();
      reset = 1'b0;
      check("rst_valid", rpt_valid, 1'b0);
      check("rst_offset", rpt_offset, 16'd0);
      check("rst_vector", rpt_vector, 8'h00);
      check("rst_af", almost_full, 1'b0);
      check("rst_ovf", overflow, 1'b0);
      check("rst_drop", dropped_count, 8'd0);

      foreach (rows[i]) begin
         drive(rows[i].run, rows[i].sod, rows[i].rv, rows[i].ready);
         tick();
         check($sformatf("row%0d_valid", i), rpt_valid, rows[i].valid);
         check($sformatf("row%0d_offset", i), rpt_offset, rows[i].off);
         check($sformatf("row%0d_vector", i), rpt_vector, rows[i].vec);
         check($sformatf("row%0d_ovf", i), overflow, rows[i].ovf);
         check($sformatf("row%0d_drop", i), dropped_count, rows[i].drop);
         check($sformatf("row%0d_af", i), almost_full, 1'b0);
      end

      // Fill with ready low: 16 stored, 2 dropped.
      do_reset();
      for (int k = 0; k < 18; k++) begin
         drive(1'b1, k == 0, 8'(k + 1), 1'b0);
         tick();
         check($sformatf("fill%0d_valid", k), rpt_valid, 1'b1);
         check($sformatf("fill%0d_head", k), rpt_offset, 16'd0);
         check($sformatf("fill%0d_af", k), almost_full, (k + 1) >= 14);
         check($sformatf("fill%0d_ovf", k), overflow, (k + 1) > 16);
         check($sformatf("fill%0d_drop", k), dropped_count, (k + 1) > 16 ? k - 15 : 0);
      end
      // Full: pop and push together, push still dropped.
      drive(1'b1, 1'b0, 8'haa, 1'b1);
      tick();
      check("fullpp_drop", dropped_count, 8'd3);
      check("fullpp_ovf", overflow, 1'b1);
      check("fullpp_count", dut.u_fifo.count, 5'd15);
      check("fullpp_af", almost_full, 1'b1);
      for (int i = 1; i < 16; i++) begin
         drive(1'b0, 1'b0, 8'h00, 1'b1);
         check($sformatf("drain%0d_offset", i), rpt_offset, 16'(i));
         check($sformatf("drain%0d_vector", i), rpt_vector, 8'(i + 1));
         tick();
         check($sformatf("drain%0d_af", i), almost_full, (15 - i) >= 14);
      end
      check("drain_empty", rpt_valid, 1'b0);
      check("drain_ovf_sticky", overflow, 1'b1);

      // Simultaneous push/pop at count 5, then random backpressure.
      do_reset();
      check("rst2_ovf", overflow, 1'b0);
      check("rst2_drop", dropped_count, 8'd0);
      model_q.delete();
      model_offs = 16'd0;
      model_drop = 0;
      sb_step(1'b1, 1'b1, 8'h01, 1'b0);
      for (int i = 0; i < 4; i++) sb_step(1'b1, 1'b0, 8'(i + 2), 1'b0);
      sb_step(1'b1, 1'b0, 8'h0f, 1'b1);
      check("pp_count5", dut.u_fifo.count, 5'd5);
      for (int i = 0; i < 300; i++) begin
         sb_step(1'($urandom_range(0, 1)), $urandom_range(0, 31) == 0,
                 ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255)),
                 1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < 20; i++) sb_step(1'b0, 1'b0, 8'h00, 1'b1);
      check("sb_final_valid", rpt_valid, 1'b0);
      check("sb_final_drop", dropped_count, 8'(model_drop));
      check("sb_final_ovf", overflow, model_drop != 0);

      // Narrow offset wrap and mid-stream restart.
      do_reset();
      drive(1'b1, 1'b1, 8'h00, 1'b0);
      tick();
      for (int i = 1; i < 16; i++) begin
         drive(1'b1, 1'b0, 8'h00, 1'b0);
         tick();
      end
      drive(1'b1, 1'b0, 8'h11, 1'b0);
      tick();
      check("wrap_valid", v4, 1'b1);
      check("wrap_offset", o4, 4'd0);
      check("wrap_vector", vec4, 8'h11);
      drive(1'b1, 1'b0, 8'h00, 1'b0);
      tick();
      drive(1'b1, 1'b1, 8'h22, 1'b0);
      tick();
      drive(1'b1, 1'b0, 8'h33, 1'b0);
      tick();
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      check("wrap_h0_off", o4, 4'd0);
      check("wrap_h0_vec", vec4, 8'h11);
      tick();
      check("wrap_h1_off", o4, 4'd0);
      check("wrap_h1_vec", vec4, 8'h22);
      tick();
      check("wrap_h2_off", o4, 4'd1);
      check("wrap_h2_vec", vec4, 8'h33);
      tick();
      check("wrap_empty", v4, 1'b0);

      // Reset mid-drain.
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, i == 0, 8'(i + 1), 1'b0);
         tick();
      end
      drive(1'b0, 1'b0, 8'h00, 1'b1);
      tick();
      check("middrain_v4", v4, 1'b1);
      check("middrain_valid", rpt_valid, 1'b1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("rstdrain_v4", v4, 1'b0);
      check("rstdrain_valid", rpt_valid, 1'b0);
      check("rstdrain_offset", rpt_offset, 16'd0);
      tick();
      check("rstdrain_stays_empty", rpt_valid, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
